// File: rtl/cq_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : cq_buffer
//  Description : Completion-queue buffer with two AXI slave ports.
//                The NVMe side writes CQ entries through an AW/W/B port; the
//                driver's poller reads them back through an AR/R port.
//                Storage is DEPTH entries of DATA_WIDTH flops starting at
//                byte address BASE (16 bytes per entry).
//  Ports       : clk, rstn         - clock, synchronous active-low reset
//                ns_aw*/ns_w*/ns_b* - AXI write port from the NVMe engine
//                cq_ar*/cq_r*       - AXI read port from the driver poller
//  Revision    : 1.0 - initial release
// ============================================================================
module cq_buffer #(
    parameter int                    ID_WIDTH   = 4,
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 128,
    parameter int                    DEPTH      = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE       = 32'h0002_0400
) (
    input  logic                    clk,
    input  logic                    rstn,
    // AW channel
    input  logic [ID_WIDTH-1:0]     ns_awid,
    input  logic [ADDR_WIDTH-1:0]   ns_awaddr,
    input  logic [7:0]              ns_awlen,
    input  logic [2:0]              ns_awsize,
    input  logic [1:0]              ns_awburst,
    input  logic                    ns_awvalid,
    output logic                    ns_awready,
    // W channel
    input  logic [DATA_WIDTH-1:0]   ns_wdata,
    input  logic [DATA_WIDTH/8-1:0] ns_wstrb,
    input  logic                    ns_wlast,
    input  logic                    ns_wvalid,
    output logic                    ns_wready,
    // B channel
    output logic [ID_WIDTH-1:0]     ns_bid,
    output logic [1:0]              ns_bresp,
    output logic                    ns_bvalid,
    input  logic                    ns_bready,
    // AR channel
    input  logic [ADDR_WIDTH-1:0]   cq_araddr,
    input  logic [7:0]              cq_arlen,
    input  logic [2:0]              cq_arsize,
    input  logic [1:0]              cq_arburst,
    input  logic                    cq_arvalid,
    output logic                    cq_arready,
    // R channel
    output logic [DATA_WIDTH-1:0]   cq_rdata,
    output logic [1:0]              cq_rresp,
    output logic                    cq_rlast,
    output logic                    cq_rvalid,
    input  logic                    cq_rready
);

    localparam int                  c_STRB_W = DATA_WIDTH / 8;
    localparam int                  c_IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Range bounds carry one extra bit so BASE + DEPTH*16 cannot wrap.
    localparam logic [ADDR_WIDTH:0] c_LO     = {1'b0, BASE};
    localparam logic [ADDR_WIDTH:0] c_HI     = c_LO + (ADDR_WIDTH+1)'(DEPTH * 16);

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wstate_t;
    typedef enum logic [0:0] {R_IDLE = 1'b0, R_DATA = 1'b1} rstate_t;

    function automatic logic f_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a} >= c_LO) && ({1'b0, a} < c_HI);
    endfunction

    function automatic logic [c_IDX_W-1:0] f_index(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE;
        return off[c_IDX_W+3:4];
    endfunction

    // FIXED bursts hold the address; INCR and WRAP both advance by the beat size.
    function automatic logic [ADDR_WIDTH-1:0] f_next(input logic [ADDR_WIDTH-1:0] a,
                                                     input logic [2:0]            size,
                                                     input logic [1:0]            burst);
        return (burst == 2'b00) ? a : a + (ADDR_WIDTH'(1) << size);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wstate_t               r_wstate;
    logic                  r_awready, r_wready, r_bvalid, r_werr;
    logic [ID_WIDTH-1:0]   r_wid, r_bid;
    logic [1:0]            r_bresp, r_wburst;
    logic [ADDR_WIDTH-1:0] r_waddr;
    logic [7:0]            r_wlen, r_wcnt;
    logic [2:0]            r_wsize;

    logic                  w_w_hit, w_w_final, w_werr_next;
    logic [c_IDX_W-1:0]    w_w_idx;

    assign w_w_hit     = f_in_range(r_waddr);
    assign w_w_idx     = f_index(r_waddr);
    assign w_w_final   = (r_wcnt == r_wlen);
    // Error accumulates over the burst: dropped beats and a misplaced wlast.
    assign w_werr_next = r_werr | ~w_w_hit | (ns_wlast != w_w_final);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= '0;
            r_werr    <= 1'b0;
            r_wid     <= '0;
            r_waddr   <= '0;
            r_wlen    <= '0;
            r_wsize   <= '0;
            r_wburst  <= '0;
            r_wcnt    <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    r_awready <= 1'b1;
                    if (ns_awvalid && r_awready) begin
                        r_wid     <= ns_awid;
                        r_waddr   <= ns_awaddr;
                        r_wlen    <= ns_awlen;
                        r_wsize   <= ns_awsize;
                        r_wburst  <= ns_awburst;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (ns_wvalid && r_wready) begin
                        if (w_w_hit) begin
                            for (int b = 0; b < c_STRB_W; b++) begin
                                if (ns_wstrb[b]) r_mem[w_w_idx][b*8 +: 8] <= ns_wdata[b*8 +: 8];
                            end
                        end
                        r_waddr <= f_next(r_waddr, r_wsize, r_wburst);
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_werr  <= w_werr_next;
                        // Burst length alone decides the end of the data phase.
                        if (w_w_final) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_wid;
                            r_bresp  <= w_werr_next ? 2'b10 : 2'b00;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (ns_bready) begin
                        r_bvalid  <= 1'b0;
                        r_werr    <= 1'b0;
                        r_awready <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    assign ns_awready = r_awready;
    assign ns_wready  = r_wready;
    assign ns_bvalid  = r_bvalid;
    assign ns_bid     = r_bid;
    assign ns_bresp   = r_bresp;

    // ------------------------------------------------------------------
    // Read side. r_raddr always points at the beat after the one held in
    // cq_rdata, so the next beat can load on the current handshake. Reads
    // sample r_mem before the same-edge write lands, returning old data.
    // ------------------------------------------------------------------
    rstate_t               r_rstate;
    logic                  r_arready, r_rvalid, r_rlast;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp, r_rburst;
    logic [ADDR_WIDTH-1:0] r_raddr;
    logic [7:0]            r_rlen, r_rcnt;
    logic [2:0]            r_rsize;

    logic                  w_ar_hit, w_rn_hit;
    logic [DATA_WIDTH-1:0] w_ar_data, w_rn_data;

    assign w_ar_hit  = f_in_range(cq_araddr);
    assign w_ar_data = w_ar_hit ? r_mem[f_index(cq_araddr)] : '0;
    assign w_rn_hit  = f_in_range(r_raddr);
    assign w_rn_data = w_rn_hit ? r_mem[f_index(r_raddr)] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= '0;
            r_raddr   <= '0;
            r_rlen    <= '0;
            r_rsize   <= '0;
            r_rburst  <= '0;
            r_rcnt    <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    r_arready <= 1'b1;
                    if (cq_arvalid && r_arready) begin
                        r_raddr   <= f_next(cq_araddr, cq_arsize, cq_arburst);
                        r_rlen    <= cq_arlen;
                        r_rsize   <= cq_arsize;
                        r_rburst  <= cq_arburst;
                        r_rcnt    <= '0;
                        r_rdata   <= w_ar_data;
                        r_rresp   <= w_ar_hit ? 2'b00 : 2'b10;
                        r_rlast   <= (cq_arlen == 8'd0);
                        r_rvalid  <= 1'b1;
                        r_arready <= 1'b0;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (cq_rready) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_rdata   <= '0;
                            r_rresp   <= '0;
                            r_arready <= 1'b1;
                            r_rstate  <= R_IDLE;
                        end else begin
                            r_rdata <= w_rn_data;
                            r_rresp <= w_rn_hit ? 2'b00 : 2'b10;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_raddr <= f_next(r_raddr, r_rsize, r_rburst);
                        end
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign cq_arready = r_arready;
    assign cq_rvalid  = r_rvalid;
    assign cq_rdata   = r_rdata;
    assign cq_rresp   = r_rresp;
    assign cq_rlast   = r_rlast;

endmodule
`default_nettype wire

// File: tb/tb_cq_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cq_buffer
//  Description : Directed self-checking bench for cq_buffer. A byte-level
//                model of the CQ storage produces expected read beats
//                (queued at AR issue) and expected write responses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cq_buffer;

    localparam logic [31:0] c_BASE = 32'h0002_0400;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [3:0]   ns_awid = '0;
    logic [31:0]  ns_awaddr = '0;
    logic [7:0]   ns_awlen = '0;
    logic [2:0]   ns_awsize = '0;
    logic [1:0]   ns_awburst = '0;
    logic         ns_awvalid = 1'b0;
    logic         ns_awready;
    logic [127:0] ns_wdata = '0;
    logic [15:0]  ns_wstrb = '0;
    logic         ns_wlast = 1'b0;
    logic         ns_wvalid = 1'b0;
    logic         ns_wready;
    logic [3:0]   ns_bid;
    logic [1:0]   ns_bresp;
    logic         ns_bvalid;
    logic         ns_bready = 1'b0;
    logic [31:0]  cq_araddr = '0;
    logic [7:0]   cq_arlen = '0;
    logic [2:0]   cq_arsize = '0;
    logic [1:0]   cq_arburst = '0;
    logic         cq_arvalid = 1'b0;
    logic         cq_arready;
    logic [127:0] cq_rdata;
    logic [1:0]   cq_rresp;
    logic         cq_rlast;
    logic         cq_rvalid;
    logic         cq_rready = 1'b0;

    cq_buffer dut (
        .clk(clk), .rstn(rstn),
        .ns_awid(ns_awid), .ns_awaddr(ns_awaddr), .ns_awlen(ns_awlen),
        .ns_awsize(ns_awsize), .ns_awburst(ns_awburst), .ns_awvalid(ns_awvalid),
        .ns_awready(ns_awready),
        .ns_wdata(ns_wdata), .ns_wstrb(ns_wstrb), .ns_wlast(ns_wlast),
        .ns_wvalid(ns_wvalid), .ns_wready(ns_wready),
        .ns_bid(ns_bid), .ns_bresp(ns_bresp), .ns_bvalid(ns_bvalid), .ns_bready(ns_bready),
        .cq_araddr(cq_araddr), .cq_arlen(cq_arlen), .cq_arsize(cq_arsize),
        .cq_arburst(cq_arburst), .cq_arvalid(cq_arvalid), .cq_arready(cq_arready),
        .cq_rdata(cq_rdata), .cq_rresp(cq_rresp), .cq_rlast(cq_rlast),
        .cq_rvalid(cq_rvalid), .cq_rready(cq_rready)
    );

    always #5 clk = ~clk;

    int           n_asserts = 0;
    int           n_fail    = 0;
    logic [127:0] model [16];
    logic [129:0] rq [$];          // expected read beats: {rresp, rdata}

    // Write-burst context of the model
    logic [3:0]   m_id;
    logic [31:0]  m_addr;
    logic [7:0]   m_len, m_cnt;
    logic [2:0]   m_size;
    logic [1:0]   m_burst;
    logic         m_err;

    task automatic check(input string tag, input logic [129:0] obs, input logic [129:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_rng(input logic [31:0] a);
        return (a >= c_BASE) && (a < c_BASE + 32'd256);
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'((a - c_BASE) >> 4);
    endfunction

    function automatic logic [31:0] step(input logic [31:0] a, input logic [2:0] size,
                                         input logic [1:0] burst);
        return (burst == 2'b00) ? a : a + (32'd1 << size);
    endfunction

    task automatic model_commit(input logic [127:0] d, input logic [15:0] s, input logic last);
        if (in_rng(m_addr)) begin
            for (int b = 0; b < 16; b++)
                if (s[b]) model[idx_of(m_addr)][b*8 +: 8] = d[b*8 +: 8];
        end
        m_err  = m_err | !in_rng(m_addr) | (last != (m_cnt == m_len));
        m_addr = step(m_addr, m_size, m_burst);
        m_cnt  = m_cnt + 8'd1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        ns_awid = id; ns_awaddr = a; ns_awlen = len; ns_awsize = size; ns_awburst = burst;
        ns_awvalid = 1'b1;
        while (!ns_awready && t < 20) begin tick; t++; end
        check("aw_timeout", 1'(t >= 20), 0);
        tick;
        ns_awvalid = 1'b0;
        m_id = id; m_addr = a; m_len = len; m_size = size; m_burst = burst;
        m_cnt = '0; m_err = 1'b0;
        check("wready_latency", ns_wready, 1);
        check("awready_drop", ns_awready, 0);
    endtask

    task automatic w_send(input logic [127:0] d, input logic [15:0] s, input logic last);
        int t = 0;
        ns_wdata = d; ns_wstrb = s; ns_wlast = last; ns_wvalid = 1'b1;
        while (!ns_wready && t < 20) begin tick; t++; end
        check("w_timeout", 1'(t >= 20), 0);
        tick;
        ns_wvalid = 1'b0;
        model_commit(d, s, last);
    endtask

    task automatic b_recv;
        check("bvalid_latency", ns_bvalid, 1);
        check("bid", ns_bid, m_id);
        check("bresp", ns_bresp, m_err ? 2'b10 : 2'b00);
        ns_bready = 1'b1;
        tick;
        ns_bready = 1'b0;
        check("bvalid_clear", ns_bvalid, 0);
        check("awready_back", ns_awready, 1);
    endtask

    task automatic rd_push(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        logic [31:0] p = a;
        for (int i = 0; i <= int'(len); i++) begin
            if (in_rng(p)) rq.push_back({2'b00, model[idx_of(p)]});
            else           rq.push_back({2'b10, 128'd0});
            p = step(p, size, burst);
        end
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int t = 0;
        rd_push(a, len, size, burst);
        cq_araddr = a; cq_arlen = len; cq_arsize = size; cq_arburst = burst;
        cq_arvalid = 1'b1;
        while (!cq_arready && t < 20) begin tick; t++; end
        check("ar_timeout", 1'(t >= 20), 0);
        tick;
        cq_arvalid = 1'b0;
        check("rvalid_latency", cq_rvalid, 1);
    endtask

    task automatic r_recv(input logic [7:0] len, input logic toggle);
        int   c = 0;
        int   beats = 0;
        logic rr, v;
        logic [129:0] exp;
        while (beats <= int'(len) && c < 200) begin
            rr = toggle ? (c % 3 == 0) : 1'b1;
            cq_rready = rr;
            exp = (rq.size() > 0) ? rq[0] : {130{1'b1}};
            check("rvalid", cq_rvalid, 1);
            check("rresp_rdata", {cq_rresp, cq_rdata}, exp);
            check("rlast", cq_rlast, 1'(beats == int'(len)));
            v = cq_rvalid;
            tick;
            if (rr && v) begin
                void'(rq.pop_front());
                beats++;
            end
            c++;
        end
        cq_rready = 1'b0;
        check("r_all_beats", 1'(rq.size() == 0), 1);
        check("rvalid_end", cq_rvalid, 0);
    endtask

    task automatic check_all_low(input string tag);
        check(tag, {ns_awready, ns_wready, ns_bvalid, ns_bid, ns_bresp,
                    cq_arready, cq_rvalid, cq_rresp, cq_rlast}, 0);
        check({tag, "_rdata"}, cq_rdata, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = '0;

        // Reset and release
        repeat (3) tick;
        check_all_low("reset_outputs");
        rstn = 1'b1;
        check_all_low("release_cycle");
        tick;
        check("awready_after_reset", ns_awready, 1);
        check("arready_after_reset", cq_arready, 1);

        // Empty entry 0 reads zero with rlast
        ar_send(c_BASE, 8'd0, 3'd4, 2'b01);
        r_recv(8'd0, 1'b0);

        // Single-beat write then read-back
        aw_send(4'd5, c_BASE + 32'h10, 8'd0, 3'd4, 2'b01);
        w_send(128'h0001_0000_0000_0000_0000_0003_0000_0000, 16'hFFFF, 1'b1);
        b_recv;
        ar_send(c_BASE + 32'h10, 8'd0, 3'd4, 2'b01);
        r_recv(8'd0, 1'b0);

        // Burst running off the top: beat 1 dropped, SLVERR
        aw_send(4'd3, c_BASE + 32'hF0, 8'd1, 3'd4, 2'b01);
        w_send(128'hAAAA_0000_1111_2222_3333_4444_5555_6666, 16'hFFFF, 1'b0);
        w_send(128'hBBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB_BBBB, 16'hFFFF, 1'b1);
        b_recv;
        ar_send(c_BASE + 32'hF0, 8'd1, 3'd4, 2'b01);   // second beat out of range
        r_recv(8'd1, 1'b0);
        ar_send(c_BASE, 8'd0, 3'd4, 2'b01);            // entry 0 untouched
        r_recv(8'd0, 1'b0);

        // Fill entries 0..3, partial strobes on beat 2, then stalled read
        aw_send(4'd1, c_BASE, 8'd3, 3'd4, 2'b10);      // WRAP behaves as INCR
        w_send(128'h1000_0000_0000_0000_0000_0000_0000_0001, 16'hFFFF, 1'b0);
        w_send(128'h2000_0000_0000_0000_0000_0000_0000_0002, 16'hFFFF, 1'b0);
        w_send(128'h3333_3333_3333_3333_3333_3333_3333_3333, 16'h00F0, 1'b0);
        w_send(128'h4000_0000_0000_0000_0000_0000_0000_0004, 16'hFFFF, 1'b1);
        b_recv;
        ar_send(c_BASE, 8'd3, 3'd4, 2'b01);
        r_recv(8'd3, 1'b1);

        // wlast asserted too early -> SLVERR even though data lands
        aw_send(4'd7, c_BASE + 32'h50, 8'd1, 3'd4, 2'b01);
        w_send(128'h5555_5555_5555_5555_5555_5555_5555_5555, 16'hFFFF, 1'b1);
        w_send(128'h6666_6666_6666_6666_6666_6666_6666_6666, 16'hFFFF, 1'b1);
        b_recv;

        // FIXED burst: both beats hit entry 7
        aw_send(4'd2, c_BASE + 32'h70, 8'd1, 3'd4, 2'b00);
        w_send(128'hCAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE_CAFE, 16'hFFFF, 1'b0);
        w_send(128'h1234_5678_9ABC_DEF0_1234_5678_9ABC_DEF0, 16'h0F0F, 1'b1);
        b_recv;
        ar_send(c_BASE + 32'h50, 8'd2, 3'd4, 2'b01);   // entries 5, 6, 7
        r_recv(8'd2, 1'b0);
        ar_send(c_BASE + 32'h70, 8'd1, 3'd4, 2'b00);
        r_recv(8'd1, 1'b0);

        // Same-edge W commit and AR capture on entry 2
        aw_send(4'd9, c_BASE + 32'h20, 8'd0, 3'd4, 2'b01);
        rd_push(c_BASE + 32'h20, 8'd0, 3'd4, 2'b01);   // pre-write contents
        check("concurrent_arready", cq_arready, 1);
        cq_araddr = c_BASE + 32'h20; cq_arlen = 8'd0; cq_arsize = 3'd4; cq_arburst = 2'b01;
        cq_arvalid = 1'b1;
        ns_wdata = 128'hFEED_FACE_DEAD_BEEF_0BAD_F00D_5A5A_A5A5;
        ns_wstrb = 16'hFFFF; ns_wlast = 1'b1; ns_wvalid = 1'b1;
        tick;
        cq_arvalid = 1'b0;
        ns_wvalid  = 1'b0;
        model_commit(128'hFEED_FACE_DEAD_BEEF_0BAD_F00D_5A5A_A5A5, 16'hFFFF, 1'b1);
        check("concurrent_rvalid", cq_rvalid, 1);
        r_recv(8'd0, 1'b0);
        b_recv;
        ar_send(c_BASE + 32'h20, 8'd0, 3'd4, 2'b01);
        r_recv(8'd0, 1'b0);

        // Reset in the middle of a write burst
        aw_send(4'd4, c_BASE, 8'd3, 3'd4, 2'b01);
        w_send(128'hDDDD_0000_0000_0000_0000_0000_0000_0001, 16'hFFFF, 1'b0);
        w_send(128'hDDDD_0000_0000_0000_0000_0000_0000_0002, 16'hFFFF, 1'b0);
        rstn = 1'b0;
        tick;
        check_all_low("midburst_reset");
        tick;
        rstn = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = '0;
        check("awready_release", ns_awready, 0);
        tick;
        check("awready_one_after", ns_awready, 1);
        check("no_bvalid_0", ns_bvalid, 0);
        tick;
        check("no_bvalid_1", ns_bvalid, 0);
        ar_send(c_BASE, 8'd3, 3'd4, 2'b01);
        r_recv(8'd3, 1'b0);
        check("no_bvalid_2", ns_bvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
